// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: steps each instruction through fetch,
// decode, execute, memory and writeback for a shared-ALU datapath.
module mips_multicycle_ctrl #(
    parameter int EN_BNE       = 1,
    parameter int EN_IMM_LOGIC = 1,
    parameter int WAIT_MEM     = 1,
    parameter int ALUOP_W      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               branch,
    output logic               branchNe,
    output logic               iord,
    output logic               wemem,
    output logic               werf,
    output logic               rfwasrc,
    output logic               memToRf,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic               extZero,
    output logic [1:0]         pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd15
    } state_t;

    typedef struct packed {
        logic               irwrite;
        logic               pcwrite;
        logic               branch;
        logic               branchNe;
        logic               iord;
        logic               wemem;
        logic               werf;
        logic               rfwasrc;
        logic               memToRf;
        logic               aluSrcA;
        logic [1:0]         aluSrcB;
        logic               extZero;
        logic [1:0]         pcsrc;
        logic [ALUOP_W-1:0] aluop;
        logic               illegal;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [ALUOP_W-1:0] AOP_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] AOP_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AOP_FN  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] AOP_AND = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] AOP_OR  = ALUOP_W'(4);

    state_t st_q, st_d;
    logic   sw_q, bne_q, andi_q, ori_q;
    logic   rdy;
    logic   is_mem, is_r, is_br, is_imm, is_j;
    logic   is_bne, is_andi, is_ori;
    ctl_t   ctl;

    assign rdy = (WAIT_MEM != 0) ? memReady : 1'b1;

    always_comb begin
        is_bne  = (EN_BNE != 0) && (opcode == OP_BNE);
        is_andi = (EN_IMM_LOGIC != 0) && (opcode == OP_ANDI);
        is_ori  = (EN_IMM_LOGIC != 0) && (opcode == OP_ORI);
        is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
        is_r    = (opcode == OP_RTYPE);
        is_br   = (opcode == OP_BEQ) || is_bne;
        is_imm  = (opcode == OP_ADDI) || is_andi || is_ori;
        is_j    = (opcode == OP_J);
    end

    // Instruction flavour is latched at DECODE so later states never see opcode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= S_FETCH;
            sw_q   <= 1'b0;
            bne_q  <= 1'b0;
            andi_q <= 1'b0;
            ori_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            if (st_q == S_DECODE) begin
                sw_q   <= (opcode == OP_SW);
                bne_q  <= is_bne;
                andi_q <= is_andi;
                ori_q  <= is_ori;
            end
        end
    end

    always_comb begin
        st_d = st_q;
        ctl  = '0;
        unique case (st_q)
            S_FETCH: begin
                ctl.aluSrcB = 2'b01;
                ctl.aluop   = AOP_ADD;
                ctl.irwrite = rdy;
                ctl.pcwrite = rdy;
                if (rdy) st_d = S_DECODE;
            end
            S_DECODE: begin
                ctl.aluSrcB = 2'b11;
                ctl.aluop   = AOP_ADD;
                unique case (1'b1)
                    is_mem:  st_d = S_MEMADR;
                    is_r:    st_d = S_EXEC;
                    is_br:   st_d = S_BRANCH;
                    is_imm:  st_d = S_IMMEX;
                    is_j:    st_d = S_JUMP;
                    default: st_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluSrcB = 2'b10;
                ctl.aluop   = AOP_ADD;
                st_d = sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctl.iord = 1'b1;
                if (rdy) st_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.werf    = 1'b1;
                ctl.memToRf = 1'b1;
                st_d = S_FETCH;
            end
            S_MEMWR: begin
                ctl.iord  = 1'b1;
                ctl.wemem = 1'b1;
                if (rdy) st_d = S_FETCH;
            end
            S_EXEC: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluop   = AOP_FN;
                st_d = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.werf    = 1'b1;
                ctl.rfwasrc = 1'b1;
                st_d = S_FETCH;
            end
            S_BRANCH: begin
                ctl.aluSrcA  = 1'b1;
                ctl.aluop    = AOP_SUB;
                ctl.branch   = 1'b1;
                ctl.branchNe = bne_q;
                ctl.pcsrc    = 2'b01;
                st_d = S_FETCH;
            end
            S_IMMEX: begin
                ctl.aluSrcA = 1'b1;
                ctl.aluSrcB = 2'b10;
                ctl.extZero = andi_q | ori_q;
                ctl.aluop   = andi_q ? AOP_AND :
                              ori_q  ? AOP_OR  : AOP_ADD;
                st_d = S_IMMWB;
            end
            S_IMMWB: begin
                ctl.werf = 1'b1;
                st_d = S_FETCH;
            end
            S_JUMP: begin
                ctl.pcwrite = 1'b1;
                ctl.pcsrc   = 2'b10;
                st_d = S_FETCH;
            end
            S_ILLEGAL: begin
                ctl.illegal = 1'b1;
            end
            default: st_d = S_FETCH;
        endcase
    end

    always_comb begin
        irwrite  = rst_n & ctl.irwrite;
        pcwrite  = rst_n & ctl.pcwrite;
        branch   = rst_n & ctl.branch;
        branchNe = rst_n & ctl.branchNe;
        iord     = rst_n & ctl.iord;
        wemem    = rst_n & ctl.wemem;
        werf     = rst_n & ctl.werf;
        rfwasrc  = rst_n & ctl.rfwasrc;
        memToRf  = rst_n & ctl.memToRf;
        aluSrcA  = rst_n & ctl.aluSrcA;
        aluSrcB  = rst_n ? ctl.aluSrcB : 2'b00;
        extZero  = rst_n & ctl.extZero;
        pcsrc    = rst_n ? ctl.pcsrc : 2'b00;
        aluop    = rst_n ? ctl.aluop : '0;
        illegal  = rst_n & ctl.illegal;
        state    = rst_n ? st_q : 4'd0;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: expected output vectors are
// queued as each cycle is driven and compared at the following falling edge.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branchNe;
        logic       iord;
        logic       wemem;
        logic       werf;
        logic       rfwasrc;
        logic       memToRf;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       extZero;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       illegal;
        logic [3:0] state;
    } ov_t;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       memReady = 1'b1;

    logic       irwrite, pcwrite, branch, branchNe, iord, wemem;
    logic       werf, rfwasrc, memToRf, aluSrcA, extZero, illegal;
    logic [1:0] aluSrcB, pcsrc;
    logic [2:0] aluop;
    logic [3:0] state;

    logic       irwrite2, pcwrite2, branch2, branchNe2, iord2, wemem2;
    logic       werf2, rfwasrc2, memToRf2, aluSrcA2, extZero2, illegal2;
    logic [1:0] aluSrcB2, pcsrc2;
    logic [2:0] aluop2;
    logic [3:0] state2;

    int    n_tests = 0;
    int    n_fail = 0;
    int    n_cyc = 0;
    bit    u2_ill = 1'b0;
    ov_t   q1[$];
    ov_t   q2[$];
    string qt[$];
    ov_t   got1, got2;

    always #5 clk = ~clk;

    mips_multicycle_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch),
        .branchNe(branchNe), .iord(iord), .wemem(wemem), .werf(werf),
        .rfwasrc(rfwasrc), .memToRf(memToRf), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .extZero(extZero), .pcsrc(pcsrc),
        .aluop(aluop), .illegal(illegal), .state(state)
    );

    mips_multicycle_ctrl #(.EN_BNE(0)) u_nobne (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .irwrite(irwrite2), .pcwrite(pcwrite2), .branch(branch2),
        .branchNe(branchNe2), .iord(iord2), .wemem(wemem2), .werf(werf2),
        .rfwasrc(rfwasrc2), .memToRf(memToRf2), .aluSrcA(aluSrcA2),
        .aluSrcB(aluSrcB2), .extZero(extZero2), .pcsrc(pcsrc2),
        .aluop(aluop2), .illegal(illegal2), .state(state2)
    );

    assign got1 = {irwrite, pcwrite, branch, branchNe, iord, wemem, werf,
                   rfwasrc, memToRf, aluSrcA, aluSrcB, extZero, pcsrc,
                   aluop, illegal, state};
    assign got2 = {irwrite2, pcwrite2, branch2, branchNe2, iord2, wemem2,
                   werf2, rfwasrc2, memToRf2, aluSrcA2, aluSrcB2, extZero2,
                   pcsrc2, aluop2, illegal2, state2};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected outputs of one state, written out from the state table.
    function automatic ov_t ex(input int st, input logic mr = 1'b1,
                               input logic ne = 1'b0, input int imm = 0);
        ov_t o;
        o = '0;
        o.state = 4'(st);
        case (st)
            0: begin
                o.aluSrcB = 2'b01;
                o.irwrite = mr;
                o.pcwrite = mr;
            end
            1: o.aluSrcB = 2'b11;
            2: begin o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; end
            3: o.iord = 1'b1;
            4: begin o.werf = 1'b1; o.memToRf = 1'b1; end
            5: begin o.iord = 1'b1; o.wemem = 1'b1; end
            6: begin o.aluSrcA = 1'b1; o.aluop = 3'b010; end
            7: begin o.werf = 1'b1; o.rfwasrc = 1'b1; end
            8: begin
                o.aluSrcA  = 1'b1;
                o.aluop    = 3'b001;
                o.branch   = 1'b1;
                o.branchNe = ne;
                o.pcsrc    = 2'b01;
            end
            9: begin
                o.aluSrcA = 1'b1;
                o.aluSrcB = 2'b10;
                o.extZero = (imm != 0);
                o.aluop   = (imm == 1) ? 3'b011 :
                            (imm == 2) ? 3'b100 : 3'b000;
            end
            10: o.werf = 1'b1;
            11: begin o.pcwrite = 1'b1; o.pcsrc = 2'b10; end
            15: o.illegal = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic cyc(input string tag, input logic [5:0] op,
                       input logic mr, input logic rst, input ov_t e);
        ov_t e2;
        @(posedge clk);
        #1;
        opcode   = op;
        memReady = mr;
        rst_n    = rst;
        if (!rst) e2 = '0;
        else if (u2_ill) e2 = ex(15);
        else e2 = e;
        q1.push_back(e);
        q2.push_back(e2);
        qt.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (q1.size() > 0) begin
            ov_t   e1, e2;
            string t;
            e1 = q1.pop_front();
            e2 = q2.pop_front();
            t  = qt.pop_front();
            n_cyc++;
            check($sformatf("%s#%0d", t, n_cyc), got1, e1);
            check($sformatf("%s_nobne#%0d", t, n_cyc), got2, e2);
        end
    end

    initial begin
        ov_t z;
        z = '0;

        cyc("rst", RT, 1, 0, z);
        cyc("rst", RT, 1, 0, z);

        cyc("lw", LW, 1, 1, ex(0));
        cyc("lw", LW, 1, 1, ex(1));
        cyc("lw", LW, 1, 1, ex(2));
        cyc("lw", LW, 1, 1, ex(3));
        cyc("lw", LW, 1, 1, ex(4));

        cyc("sw", SW, 1, 1, ex(0));
        cyc("sw", SW, 1, 1, ex(1));
        cyc("sw", SW, 1, 1, ex(2));
        cyc("sw", SW, 0, 1, ex(5));
        cyc("sw", SW, 0, 1, ex(5));
        cyc("sw", SW, 0, 1, ex(5));
        cyc("sw", SW, 1, 1, ex(5));

        cyc("rt", RT, 0, 1, ex(0, 0));
        cyc("rt", RT, 1, 1, ex(0));
        cyc("rt", RT, 1, 1, ex(1));
        cyc("rt", RT, 1, 1, ex(6));
        cyc("rt", RT, 1, 1, ex(7));

        cyc("beq", BEQ, 1, 1, ex(0));
        cyc("beq", BEQ, 1, 1, ex(1));
        cyc("beq", BEQ, 1, 1, ex(8, 1, 0));

        cyc("addi", ADDI, 1, 1, ex(0));
        cyc("addi", ADDI, 1, 1, ex(1));
        cyc("addi", ADDI, 1, 1, ex(9, 1, 0, 0));
        cyc("addi", ADDI, 1, 1, ex(10));

        cyc("andi", ANDI, 1, 1, ex(0));
        cyc("andi", ANDI, 1, 1, ex(1));
        cyc("andi", ANDI, 1, 1, ex(9, 1, 0, 1));
        cyc("andi", ANDI, 1, 1, ex(10));

        cyc("ori", ORI, 1, 1, ex(0));
        cyc("ori", ORI, 1, 1, ex(1));
        cyc("ori", ORI, 1, 1, ex(9, 1, 0, 2));
        cyc("ori", ORI, 1, 1, ex(10));

        cyc("j", JMP, 1, 1, ex(0));
        cyc("j", JMP, 1, 1, ex(1));
        cyc("j", JMP, 1, 1, ex(11));

        cyc("lwwait", LW, 1, 1, ex(0));
        cyc("lwwait", LW, 1, 1, ex(1));
        cyc("lwwait", LW, 1, 1, ex(2));
        cyc("lwwait", LW, 0, 1, ex(3));
        cyc("lwwait", LW, 0, 1, ex(3));
        cyc("lwwait", LW, 1, 1, ex(3));
        cyc("lwwait", LW, 1, 1, ex(4));

        cyc("bne", BNE, 1, 1, ex(0));
        cyc("bne", BNE, 1, 1, ex(1));
        u2_ill = 1'b1;
        cyc("bne", BNE, 1, 1, ex(8, 1, 1));
        cyc("j2", JMP, 1, 1, ex(0));
        cyc("j2", JMP, 1, 1, ex(1));
        cyc("j2", JMP, 1, 1, ex(11));

        cyc("bad", BAD, 1, 1, ex(0));
        cyc("bad", BAD, 1, 1, ex(1));
        cyc("bad", BAD, 1, 1, ex(15));
        cyc("bad", RT, 0, 1, ex(15));
        cyc("bad", LW, 1, 1, ex(15));
        cyc("badrst", LW, 1, 0, z);
        u2_ill = 1'b0;
        cyc("badrst", LW, 1, 1, ex(0));

        cyc("swrst", SW, 1, 1, ex(1));
        cyc("swrst", SW, 1, 1, ex(2));
        cyc("swrst", SW, 0, 1, ex(5));
        cyc("swrst", SW, 0, 0, z);
        cyc("swrst", RT, 1, 1, ex(0));

        cyc("rtrst", RT, 1, 1, ex(1));
        cyc("rtrst", RT, 1, 1, ex(6));
        cyc("rtrst", RT, 1, 0, z);
        cyc("rtrst", RT, 1, 1, ex(0));
        cyc("rtrst", RT, 1, 1, ex(1));

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle MIPS main decoder: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the shared-ALU / unified-memory datapath.
- Adds optional bne, andi and ori support, a memory-ready wait handshake, and a sticky illegal-opcode trap.
- Sits between the instruction register opcode field and the datapath enables.

Parameters:
- EN_BNE, 1, 1 = decode bne (000101); 0 = treat it as illegal.
- EN_IMM_LOGIC, 1, 1 = decode andi (001100) and ori (001101); 0 = illegal.
- WAIT_MEM, 1, 1 = FETCH/MEMRD/MEMWR hold until memReady; 0 = memReady ignored, treated as 1.
- ALUOP_W, 3, aluop width; must be ≥3.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- memReady  in  1  memory access complete this cycle.
- irwrite  out  1  load instruction register.
- pcwrite  out  1  unconditional PC write.
- branch  out  1  conditional PC write.
- branchNe  out  1  with branch: take the branch when zero=0 (bne).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- wemem  out  1  memory write enable.
- werf  out  1  register file write enable.
- rfwasrc  out  1  write register: 0 = rt, 1 = rd.
- memToRf  out  1  write data: 0 = ALUOut, 1 = data register.
- aluSrcA  out  1  0 = PC, 1 = rs.
- aluSrcB  out  2  00 = rt, 01 = constant 4, 10 = immediate, 11 = immediate<<2.
- extZero  out  1  immediate zero-extended (andi/ori) instead of sign-extended.
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  out  ALUOP_W  000 add, 001 sub, 010 funct-decoded, 011 and, 100 or.
- illegal  out  1  sticky illegal-opcode flag.
- state  out  4  current state code (debug).

Behaviour:
- Reset: rst_n sampled low at a rising edge sets state to FETCH (code 0).
- While rst_n is low, every output is forced to 0 combinationally, including state. Reset wins over any other event in the same cycle, including during a memory wait and in ILLEGAL.
- All other outputs are a pure function of state, plus memReady where stated. No opcode-to-output combinational path except through the DECODE transition.
- In every state, any output not listed for that state is 0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, ILLEGAL 15.
- FETCH: iord=0, aluSrcA=0, aluSrcB=01, aluop=add, pcsrc=00; irwrite=pcwrite=memReady. Advance to DECODE when memReady=1, else hold.
- DECODE: aluSrcA=0, aluSrcB=11, aluop=add (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEMADR
  - 000000 → EXEC
  - beq, and bne when enabled → BRANCH
  - addi, and andi/ori when enabled → IMMEX
  - j → JUMP
  - anything else → ILLEGAL
- MEMADR: aluSrcA=1, aluSrcB=10, aluop=add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Hold until memReady, then MEMWB.
- MEMWB: werf=1, memToRf=1, rfwasrc=0. Next FETCH.
- MEMWR: iord=1, wemem=1. Hold until memReady, then FETCH. wemem stays asserted while holding.
- EXEC: aluSrcA=1, aluSrcB=00, aluop=funct. Next ALUWB.
- ALUWB: werf=1, rfwasrc=1, memToRf=0. Next FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluop=sub, branch=1, pcsrc=01; branchNe=1 for bne only. Next FETCH.
- IMMEX: aluSrcA=1, aluSrcB=10. aluop: addi=add, andi=and, ori=or. extZero=1 for andi/ori. Next IMMWB.
- IMMWB: werf=1, rfwasrc=0, memToRf=0. Next FETCH.
  - The opcode must stay stable from DECODE through writeback; the instruction register is not written outside FETCH.
- JUMP: pcwrite=1, pcsrc=10. Next FETCH.
- ILLEGAL: illegal=1, all enables 0. Held until reset.
- Cycle counts with memReady constantly 1: lw 5, sw 4, R-type 4, beq/bne 3, imm 4, j 3. Each memReady-low cycle adds one cycle in FETCH/MEMRD/MEMWR.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 → all outputs 0 during reset; state=0 and irwrite=pcwrite=1 in the first cycle after release.
- lw, memReady=1: opcode=100011 → states 0,1,2,3,4,0; werf=memToRf=1 only in state 4.
- sw with wait: opcode=101011, memReady low for 3 cycles in MEMWR → state 5 held 4 cycles, wemem=1 throughout, then FETCH.
- bne: opcode=000101 → BRANCH with branch=branchNe=1, aluop=001. Same opcode with EN_BNE=0 → state 15, illegal=1, held until rst_n=0.
- ori: opcode=001101 → IMMEX with aluop=100, extZero=1, then IMMWB with werf=1, rfwasrc=0.
- j, then R-type: opcode=000010 → pcwrite=1, pcsrc=10 in state 11; then opcode=000000 → EXEC with aluop=010, ALUWB with rfwasrc=1. Assert rst_n=0 mid-EXEC → state 0 at the next edge.
